// File: rtl/branch_pht_sched_pkg.sv
// Shared types and helpers for the PHT scheduler: FSM/grant enums, history snapshot entry, 2-bit counter update.
package branch_pht_sched_pkg;

    typedef enum logic {INIT = 1'b0, RUN = 1'b1} state_t;
    typedef enum logic {PRED = 1'b0, RES = 1'b1} grant_t;

    // Snapshot field is sized for the largest supported table (PHT_SIZE <= 2**16); narrower GHRs zero-extend.
    localparam int SNAP_MAX_W = 16;

    typedef struct packed {
        logic [SNAP_MAX_W-1:0] snap;
        logic                  pred;
    } hist_entry_t;

    function automatic logic [1:0] sat_update(input logic [1:0] cnt, input logic taken);
        logic [1:0] nxt;
        nxt = cnt;
        if (taken && cnt != 2'b11) begin
            nxt = cnt + 2'b01;
        end else if (!taken && cnt != 2'b00) begin
            nxt = cnt - 2'b01;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/branch_pht_sched_histq.sv
// In-order FIFO of per-branch history snapshots; flush empties it and takes priority over push.
module branch_pht_sched_histq
    import branch_pht_sched_pkg::*;
#(
    parameter  int QDEPTH = 8,
    localparam int TW     = $clog2(QDEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  hist_entry_t   din,
    input  logic          pop,
    input  logic          flush,
    output logic          full,
    output logic          empty,
    output hist_entry_t   head,
    output logic [TW-1:0] wr_tag
);

    localparam logic [TW:0] PTR_ONE = {{TW{1'b0}}, 1'b1};

    logic [TW:0] wr_ptr_q, wr_ptr_d;
    logic [TW:0] rd_ptr_q, rd_ptr_d;
    hist_entry_t mem_q [QDEPTH];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush) begin
            rd_ptr_d = wr_ptr_q;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem_q[wr_ptr_q[TW-1:0]] <= din;
        end
    end

    // Extra wrap bit distinguishes full from empty when the slot indices match.
    assign empty  = (wr_ptr_q == rd_ptr_q);
    assign full   = (wr_ptr_q[TW] != rd_ptr_q[TW]) && (wr_ptr_q[TW-1:0] == rd_ptr_q[TW-1:0]);
    assign head   = mem_q[rd_ptr_q[TW-1:0]];
    assign wr_tag = wr_ptr_q[TW-1:0];

endmodule

// File: rtl/branch_pht_sched.sv
// Single-port PHT scheduler: init sweep, predict/resolve arbitration, speculative GHR with mispredict recovery.
// Optional counters stat_preds/stat_mispreds are built when BRANCH_PHT_SCHED_STATS_EN is defined.
module branch_pht_sched
    import branch_pht_sched_pkg::*;
#(
    parameter  int PHT_SIZE = 2048,
    parameter  int QDEPTH   = 8,
    localparam int IW       = $clog2(PHT_SIZE),
    localparam int TW       = $clog2(QDEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          pred_req_val,
    output logic          pred_req_rdy,
    output logic          pred_resp_val,
    input  logic          pred_resp_rdy,
    output logic          pred_resp_taken,
    output logic [TW-1:0] pred_resp_tag,
    input  logic          res_val,
    output logic          res_rdy,
    input  logic          res_taken,
    output logic          flush,
    output logic          pht_wen,
    output logic [IW-1:0] pht_addr,
    output logic [1:0]    pht_wdata,
    input  logic [1:0]    pht_rdata,
    output logic [31:0]   stat_preds,
    output logic [31:0]   stat_mispreds
);

    localparam logic [IW-1:0] CNT_ONE  = {{(IW-1){1'b0}}, 1'b1};
    localparam logic [IW-1:0] CNT_LAST = IW'(PHT_SIZE - 1);

    state_t        state_q, state_d;
    grant_t        last_grant_q, last_grant_d;
    logic [IW-1:0] cnt_q, cnt_d;
    logic [IW-1:0] ghr_q, ghr_d;
    logic          resp_val_q, resp_val_d;
    logic          resp_taken_q, resp_taken_d;
    logic [TW-1:0] resp_tag_q, resp_tag_d;
    logic          flush_q, flush_d;

    logic          q_push, q_pop, q_flush, q_full, q_empty;
    hist_entry_t   q_din, q_head;
    logic [TW-1:0] q_wr_tag;

    logic res_cand, pred_cand, grant_res, grant_pred, mispredict;

    branch_pht_sched_histq #(.QDEPTH(QDEPTH)) u_histq (
        .clk    (clk),
        .rst    (reset),
        .push   (q_push),
        .din    (q_din),
        .pop    (q_pop),
        .flush  (q_flush),
        .full   (q_full),
        .empty  (q_empty),
        .head   (q_head),
        .wr_tag (q_wr_tag)
    );

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        ghr_d        = ghr_q;
        resp_val_d   = resp_val_q;
        resp_taken_d = resp_taken_q;
        resp_tag_d   = resp_tag_q;
        flush_d      = 1'b0;
        q_push       = 1'b0;
        q_pop        = 1'b0;
        q_flush      = 1'b0;
        q_din        = '0;
        pht_wen      = 1'b0;
        pht_addr     = ghr_q;
        pht_wdata    = 2'b01;
        mispredict   = 1'b0;

        // A pending response may be consumed in the same cycle a new prediction refills the slot.
        res_cand   = (state_q == RUN) && res_val && !q_empty;
        pred_cand  = (state_q == RUN) && pred_req_val && !q_full && (!resp_val_q || pred_resp_rdy);
        grant_res  = res_cand && (!pred_cand || last_grant_q == PRED);
        grant_pred = pred_cand && !grant_res;

        if (resp_val_q && pred_resp_rdy) resp_val_d = 1'b0;

        case (state_q)
            INIT: begin
                pht_wen   = !reset;
                pht_addr  = cnt_q;
                pht_wdata = 2'b01;
                cnt_d     = cnt_q + CNT_ONE;
                if (cnt_q == CNT_LAST) state_d = RUN;
            end
            RUN: begin
                if (grant_res) begin
                    last_grant_d = RES;
                    q_pop        = 1'b1;
                    pht_wen      = 1'b1;
                    pht_addr     = IW'(q_head.snap);
                    pht_wdata    = sat_update(pht_rdata, res_taken);
                    if (res_taken != q_head.pred) begin
                        // Everything younger than the resolving branch was fetched down the wrong path.
                        mispredict = 1'b1;
                        ghr_d      = IW'({q_head.snap, res_taken});
                        q_flush    = 1'b1;
                        resp_val_d = 1'b0;
                        flush_d    = 1'b1;
                    end
                end else if (grant_pred) begin
                    last_grant_d = PRED;
                    q_push       = 1'b1;
                    q_din        = '{snap: SNAP_MAX_W'(ghr_q), pred: pht_rdata[1]};
                    ghr_d        = {ghr_q[IW-2:0], pht_rdata[1]};
                    resp_val_d   = 1'b1;
                    resp_taken_d = pht_rdata[1];
                    resp_tag_d   = q_wr_tag;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= INIT;
            last_grant_q <= PRED;
            cnt_q        <= '0;
            ghr_q        <= '0;
            resp_val_q   <= 1'b0;
            resp_taken_q <= 1'b0;
            resp_tag_q   <= '0;
            flush_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            ghr_q        <= ghr_d;
            resp_val_q   <= resp_val_d;
            resp_taken_q <= resp_taken_d;
            resp_tag_q   <= resp_tag_d;
            flush_q      <= flush_d;
        end
    end

    assign pred_req_rdy    = grant_pred;
    assign res_rdy         = grant_res;
    assign pred_resp_val   = resp_val_q;
    assign pred_resp_taken = resp_taken_q;
    assign pred_resp_tag   = resp_tag_q;
    assign flush           = flush_q;

`ifdef BRANCH_PHT_SCHED_STATS_EN
    logic [31:0] stat_preds_q, stat_preds_d;
    logic [31:0] stat_mispreds_q, stat_mispreds_d;

    always_comb begin
        stat_preds_d    = stat_preds_q + {31'b0, grant_pred};
        stat_mispreds_d = stat_mispreds_q + {31'b0, mispredict};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_preds_q    <= '0;
            stat_mispreds_q <= '0;
        end else begin
            stat_preds_q    <= stat_preds_d;
            stat_mispreds_q <= stat_mispreds_d;
        end
    end

    assign stat_preds    = stat_preds_q;
    assign stat_mispreds = stat_mispreds_q;
`else
    assign stat_preds    = '0;
    assign stat_mispreds = '0;
`endif

endmodule
